// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared encodings for the program-counter generator.
//   pc_sel_e : 2-bit next-PC mode select (NOJUMP/J_OFFSET keep their legacy codes)
//   state_e  : fetch FSM states
//   PC_STEP  : sequential instruction stride in bytes
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_NOJUMP   = 2'b00,
    PC_J_OFFSET = 2'b01,
    PC_JALR     = 2'b10,
    PC_TRAP     = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_gen_npc_calc.sv
// pc_gen_npc_calc: combinational next-PC computation.
//   Inputs : pc, pc_sel, imm_ext, rs1, mtvec, trap_req
//   Outputs: npc       - value the PC register loads on retirement
//            misalign  - selected jump target is misaligned and is being
//                        redirected to the trap vector (never set on trap_req)
//            take_trap - trap_req or misaligned redirect; mepc must capture pc
module pc_gen_npc_calc
  import pc_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] mtvec,
  input  logic            trap_req,
  output logic [XLEN-1:0] npc,
  output logic            misalign,
  output logic            take_trap
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  pc_sel_e         sel;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            check_align;
  logic            bad_align;

  assign sel      = pc_sel_e'(pc_sel);
  // Trap vector is always used in direct mode: mode bits [1:0] are dropped.
  assign trap_vec = {mtvec[XLEN-1:2], 2'b00};
  assign jalr_sum = rs1 + imm_ext;

  always_comb begin
    target      = pc + STEP;
    check_align = 1'b0;
    case (sel)
      PC_J_OFFSET: begin
        target      = pc + imm_ext;
        check_align = 1'b1;
      end
      PC_JALR: begin
        target      = {jalr_sum[XLEN-1:1], 1'b0};
        check_align = 1'b1;
      end
      PC_TRAP:  target = trap_vec;
      default:  target = pc + STEP;
    endcase
  end

  // Only computed control transfers can be misaligned; sequential and trap
  // targets are aligned by construction.
  assign bad_align = check_align && ((target & ALIGN_MASK) != '0);
  assign take_trap = trap_req || bad_align;
  assign misalign  = bad_align && !trap_req;
  assign npc       = take_trap ? trap_vec : target;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: architectural PC register with instruction fetch handshake.
//   clk, rst_n                       : clock, async active-low reset
//   pc_sel, imm_ext, rs1, mtvec      : next-PC mode and operands
//   trap_req, instr_done             : retirement controls (sampled in EXEC)
//   imem_req, imem_addr, imem_ack    : fetch handshake (req held until ack)
//   pc, npc                          : current PC, next-PC preview
//   misalign                         : one-cycle pulse after misaligned redirect
//   mepc                             : PC of last trapping instruction
//   busy                             : high while in FETCH
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] mtvec,
  input  logic            trap_req,
  input  logic            instr_done,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            misalign,
  output logic [XLEN-1:0] mepc,
  output logic            busy
);

  state_e          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] mepc_reg;
  logic            req_reg;
  logic            misalign_reg;

  logic [XLEN-1:0] npc_calc;
  logic            redirect_mis;
  logic            take_trap;

  pc_gen_npc_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_npc_calc (
    .pc        (pc_reg),
    .pc_sel    (pc_sel),
    .imm_ext   (imm_ext),
    .rs1       (rs1),
    .mtvec     (mtvec),
    .trap_req  (trap_req),
    .npc       (npc_calc),
    .misalign  (redirect_mis),
    .take_trap (take_trap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_VEC;
      mepc_reg     <= '0;
      req_reg      <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      // misalign is a pulse: cleared every cycle unless re-armed below.
      misalign_reg <= 1'b0;
      case (state_reg)
        ST_BOOT: begin
          state_reg <= ST_FETCH;
          req_reg   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            state_reg <= ST_EXEC;
            req_reg   <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (instr_done) begin
            pc_reg       <= npc_calc;
            misalign_reg <= redirect_mis;
            if (take_trap) begin
              mepc_reg <= pc_reg;
            end
            state_reg <= ST_FETCH;
            req_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_BOOT;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign imem_req  = req_reg;
  assign busy      = req_reg;   // request is asserted exactly while in FETCH
  assign npc       = npc_calc;
  assign misalign  = misalign_reg;
  assign mepc      = mepc_reg;

endmodule
